// File: rtl/mercury_ddio_pkg.sv
// mercury_ddio_pkg: shared phase encoding and parameter helpers for the DDR input deserialiser
package mercury_ddio_pkg;
   typedef enum logic {PH_H = 1'b0, PH_L = 1'b1} phase_e;
   function automatic logic pu_bit(input string mode);
      return mode == "high";
   endfunction
   function automatic int cnt_w(input int ratio);
      return ratio > 1 ? $clog2(ratio) : 1;
   endfunction
endpackage

// File: rtl/mercury_ddio_in_deser_if.sv
// mercury_ddio_in_deser_if: pad-side inputs and core-side outputs of the DDR input deserialiser
interface mercury_ddio_in_deser_if #(parameter int WIDTH = 1, parameter int RATIO = 4);
   logic clkena, bitslip, word_valid, slip_busy;
   logic [WIDTH-1:0] datain, dataout_h, dataout_l;
   logic [2*WIDTH*RATIO-1:0] word_out;
   modport master(output clkena, bitslip, datain, input dataout_h, dataout_l, word_out, word_valid, slip_busy);
   modport slave(input clkena, bitslip, datain, output dataout_h, dataout_l, word_out, word_valid, slip_busy);
endinterface

// File: rtl/mercury_ddio_cap.sv
// mercury_ddio_cap: per-lane DDR capture, edge-aligned h/l registers and phase-selected beat pair
module mercury_ddio_cap
   import mercury_ddio_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter logic PU_BIT = 1'b0
) (
   input logic clk,
   input logic sclr,
   input logic clkena,
   input phase_e phase,
   input logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout_h,
   output logic [WIDTH-1:0] dataout_l,
   output logic [WIDTH-1:0] beat0,
   output logic [WIDTH-1:0] beat1
);
   logic [WIDTH-1:0] pos_q, pos_d, neg_q, neg_d, h_q, h_d, l_q, l_d;
   always_comb begin
      pos_d = clkena ? datain : pos_q;
      neg_d = clkena ? datain : neg_q;
      h_d = clkena ? pos_q : h_q;
      l_d = clkena ? neg_q : l_q;
      // odd phase pairs the previous falling beat with the current rising one
      beat0 = phase == PH_L ? l_q : pos_q;
      beat1 = phase == PH_L ? pos_q : neg_q;
   end
   always_ff @(posedge clk) begin
      if (sclr) begin
         pos_q <= '0;
         h_q <= {WIDTH{PU_BIT}};
         l_q <= {WIDTH{PU_BIT}};
      end else begin
         pos_q <= pos_d;
         h_q <= h_d;
         l_q <= l_d;
      end
   end
   always_ff @(negedge clk) begin
      if (sclr) neg_q <= '0;
      else neg_q <= neg_d;
   end
   assign dataout_h = h_q;
   assign dataout_l = l_q;
endmodule

// File: rtl/mercury_ddio_in_deser.sv
// mercury_ddio_in_deser: WIDTH-lane DDR capture with 1:RATIO packing and beat-level bitslip
module mercury_ddio_in_deser
   import mercury_ddio_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int RATIO = 4,
   parameter string POWER_UP_MODE = "low"
) (
   input logic clk,
   input logic sclr,
   mercury_ddio_in_deser_if.slave io
);
   localparam int BW = 2 * WIDTH;
   localparam int NW = BW * RATIO;
   localparam int CW = cnt_w(RATIO);
   localparam logic PU_BIT = pu_bit(POWER_UP_MODE);
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
   phase_e phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NW-1:0] sh_q, sh_d, word_q, word_d, nxt;
   logic [WIDTH-1:0] b0, b1;
   logic prime_q, prime_d, stall_q, stall_d, busy_q, busy_d, valid_q, valid_d;
   logic pack, accept, done;
   mercury_ddio_cap #(.WIDTH(WIDTH), .PU_BIT(PU_BIT)) u_cap (
      .clk,
      .sclr,
      .clkena(io.clkena),
      .phase(phase_q),
      .datain(io.datain),
      .dataout_h(io.dataout_h),
      .dataout_l(io.dataout_l),
      .beat0(b0),
      .beat1(b1)
   );
   always_comb begin
      // pairs are only meaningful once one enabled edge has loaded the capture regs
      pack = io.clkena & prime_q;
      accept = io.clkena & io.bitslip & ~busy_q;
      done = pack & ~stall_q & ~accept & (cnt_q == LAST);
      nxt = NW'({b1, b0, sh_q} >> BW);
      sh_d = pack ? nxt : sh_q;
      word_d = done ? nxt : word_q;
      valid_d = done;
      prime_d = prime_q | io.clkena;
      phase_d = accept ? (phase_q == PH_H ? PH_L : PH_H) : phase_q;
      // leaving the odd phase skips a beat, so drop one pair to net a one-beat delay
      stall_d = accept ? phase_q == PH_L : (pack ? 1'b0 : stall_q);
      cnt_d = accept | done ? '0 : (pack & ~stall_q ? cnt_q + CW'(1) : cnt_q);
      busy_d = io.clkena ? accept | (busy_q & ~valid_q) : busy_q;
   end
   always_ff @(posedge clk) begin
      if (sclr) begin
         phase_q <= PH_H;
         cnt_q <= '0;
         sh_q <= '0;
         word_q <= {NW{PU_BIT}};
         valid_q <= 1'b0;
         prime_q <= 1'b0;
         stall_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q <= cnt_d;
         sh_q <= sh_d;
         word_q <= word_d;
         valid_q <= valid_d;
         prime_q <= prime_d;
         stall_q <= stall_d;
         busy_q <= busy_d;
      end
   end
   assign io.word_out = word_q;
   assign io.word_valid = valid_q;
   assign io.slip_busy = busy_q;
endmodule

// File: tb/tb_mercury_ddio_in_deser.sv
// tb_mercury_ddio_in_deser: directed scoreboard bench for a RATIO=1 "low" and a RATIO=4 "high" instance
module tb_mercury_ddio_in_deser;
   typedef struct {int unsigned cyc; logic [31:0] w;} exp_t;
   logic clk = 1'b0;
   logic sclr;
   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   mercury_ddio_in_deser_if #(.WIDTH(4), .RATIO(1)) ifa ();
   mercury_ddio_in_deser_if #(.WIDTH(4), .RATIO(4)) ifb ();
   mercury_ddio_in_deser #(.WIDTH(4), .RATIO(1), .POWER_UP_MODE("low")) dut_a (.clk(clk), .sclr(sclr), .io(ifa));
   mercury_ddio_in_deser #(.WIDTH(4), .RATIO(4), .POWER_UP_MODE("high")) dut_b (.clk(clk), .sclr(sclr), .io(ifb));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (ifa.word_valid === 1'b1) begin
         if (qa.size() == 0) chk("a_extra_word", 64'(ifa.word_valid), 64'd0);
         else begin
            e = qa.pop_front();
            chk("a_word", 64'(ifa.word_out), 64'(e.w));
            chk("a_word_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (ifb.word_valid === 1'b1) begin
         if (qb.size() == 0) chk("b_extra_word", 64'(ifb.word_valid), 64'd0);
         else begin
            e = qb.pop_front();
            chk("b_word", 64'(ifb.word_out), 64'(e.w));
            chk("b_word_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // one clk cycle: rb/ra sampled on the rising edge, fb/fa on the following falling edge
   task automatic tick(input logic [3:0] rb, input logic [3:0] fb, input logic enb, input logic slb,
                       input logic rs, input logic [3:0] ra, input logic [3:0] fa, input logic ena);
      sclr = rs;
      ifb.datain = rb;
      ifb.clkena = enb;
      ifb.bitslip = slb;
      ifa.datain = ra;
      ifa.clkena = ena;
      ifa.bitslip = 1'b0;
      @(posedge clk);
      #2;
      ifb.datain = fb;
      ifa.datain = fa;
      @(negedge clk);
      #2;
   endtask

   // cycle c of the B stream carries beats 2c-1 (rise) and 2c (fall)
   task automatic beat(input int c, input logic en, input logic sl, input logic rs);
      tick(4'(2 * c - 1), 4'(2 * c), en, sl, rs, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic reset_all();
      repeat (2) tick(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
   endtask

   initial begin
      logic [3:0] ra_t [7];
      logic [3:0] fa_t [7];
      int unsigned t0;
      ra_t = '{4'hA, 4'hA, 4'hA, 4'h3, 4'hF, 4'hA, 4'hA};
      fa_t = '{4'h5, 4'h5, 4'h5, 4'hC, 4'h0, 4'h5, 4'h5};
      sclr = 1'b1;
      ifa.clkena = 1'b0;
      ifa.bitslip = 1'b0;
      ifa.datain = '0;
      ifb.clkena = 1'b0;
      ifb.bitslip = 1'b0;
      ifb.datain = '0;
      reset_all();
      chk("a_rst_h", 64'(ifa.dataout_h), 64'h0);
      chk("a_rst_l", 64'(ifa.dataout_l), 64'h0);
      chk("a_rst_word", 64'(ifa.word_out), 64'h0);
      chk("a_rst_valid", 64'(ifa.word_valid), 64'h0);
      chk("b_rst_h", 64'(ifb.dataout_h), 64'hF);
      chk("b_rst_l", 64'(ifb.dataout_l), 64'hF);
      chk("b_rst_word", 64'(ifb.word_out), 64'hFFFF_FFFF);
      chk("b_rst_valid", 64'(ifb.word_valid), 64'h0);
      chk("b_rst_busy", 64'(ifb.slip_busy), 64'h0);

      // RATIO=1: every enabled cycle after the first yields {fall, rise} of the previous cycle
      t0 = cyc;
      qa.push_back('{cyc: t0 + 2, w: 32'h5A});
      qa.push_back('{cyc: t0 + 3, w: 32'h5A});
      qa.push_back('{cyc: t0 + 4, w: 32'h5A});
      qa.push_back('{cyc: t0 + 5, w: 32'hC3});
      qa.push_back('{cyc: t0 + 6, w: 32'h0F});
      qa.push_back('{cyc: t0 + 7, w: 32'h5A});
      for (int i = 0; i < 7; i++) begin
         tick(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, ra_t[i], fa_t[i], 1'b1);
         if (i == 0) chk("a_h_first", 64'(ifa.dataout_h), 64'h0);
         if (i == 1) chk("a_h", 64'(ifa.dataout_h), 64'hA);
         if (i == 1) chk("a_l", 64'(ifa.dataout_l), 64'h5);
         if (i == 4) chk("a_h_var", 64'(ifa.dataout_h), 64'h3);
         if (i == 4) chk("a_l_var", 64'(ifa.dataout_l), 64'hC);
      end
      tick(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

      // RATIO=4 packing of beats 1..16
      reset_all();
      t0 = cyc;
      qb.push_back('{cyc: t0 + 5, w: 32'h8765_4321});
      qb.push_back('{cyc: t0 + 9, w: 32'h0FED_CBA9});
      for (int c = 1; c <= 9; c++) begin
         beat(c, 1'b1, 1'b0, 1'b0);
         if (c == 1) chk("b_h_cleared", 64'(ifb.dataout_h), 64'h0);
         if (c == 3) chk("b_h", 64'(ifb.dataout_h), 64'h3);
         if (c == 3) chk("b_l", 64'(ifb.dataout_l), 64'h4);
      end

      // single slip on the first pair: next word starts on a falling beat
      reset_all();
      t0 = cyc;
      qb.push_back('{cyc: t0 + 6, w: 32'h9876_5432});
      qb.push_back('{cyc: t0 + 10, w: 32'h10FE_DCBA});
      for (int c = 1; c <= 10; c++) begin
         beat(c, 1'b1, c == 2, 1'b0);
         chk("slip1_busy", 64'(ifb.slip_busy), 64'(c >= 2 && c <= 6));
      end

      // slip, ignored slip while busy, then a second accepted slip back to phase 0
      reset_all();
      t0 = cyc;
      qb.push_back('{cyc: t0 + 6, w: 32'h9876_5432});
      qb.push_back('{cyc: t0 + 13, w: 32'h8765_4321});
      for (int c = 1; c <= 14; c++) begin
         beat(c, 1'b1, c == 2 || c == 4 || c == 8, 1'b0);
         chk("slip2_busy", 64'(ifb.slip_busy), 64'((c >= 2 && c <= 6) || (c >= 8 && c <= 13)));
      end

      // clkena low for three cycles mid-word
      reset_all();
      t0 = cyc;
      qb.push_back('{cyc: t0 + 8, w: 32'h8765_4321});
      for (int c = 1; c <= 3; c++) beat(c, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
         chk("stall_h", 64'(ifb.dataout_h), 64'h3);
         chk("stall_l", 64'(ifb.dataout_l), 64'h4);
         chk("stall_valid", 64'(ifb.word_valid), 64'h0);
      end
      beat(4, 1'b1, 1'b0, 1'b0);
      chk("resume_h", 64'(ifb.dataout_h), 64'h5);
      chk("resume_l", 64'(ifb.dataout_l), 64'h6);
      beat(5, 1'b1, 1'b0, 1'b0);

      // sclr with cnt=2 discards the partial word and restores power-up ones
      reset_all();
      for (int c = 1; c <= 3; c++) beat(c, 1'b1, 1'b0, 1'b0);
      beat(4, 1'b1, 1'b0, 1'b1);
      chk("mid_rst_h", 64'(ifb.dataout_h), 64'hF);
      chk("mid_rst_l", 64'(ifb.dataout_l), 64'hF);
      chk("mid_rst_word", 64'(ifb.word_out), 64'hFFFF_FFFF);
      chk("mid_rst_valid", 64'(ifb.word_valid), 64'h0);
      t0 = cyc;
      qb.push_back('{cyc: t0 + 5, w: 32'h8765_4321});
      for (int c = 1; c <= 5; c++) beat(c, 1'b1, 1'b0, 1'b0);

      repeat (2) tick(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      chk("a_missing_words", 64'(qa.size()), 64'd0);
      chk("b_missing_words", 64'(qb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
